// File: rtl/button_pkg.sv
// Shared constants for the push-button controller: register offsets on addr[10:8],
// CTRL bit positions, the reserved-read pattern and the board's button bit order.
package button_pkg;

   localparam logic [2:0] REG_LEVEL   = 3'd0;
   localparam logic [2:0] REG_PRESS   = 3'd1;
   localparam logic [2:0] REG_RELEASE = 3'd2;
   localparam logic [2:0] REG_MASK    = 3'd3;
   localparam logic [2:0] REG_CTRL    = 3'd4;

   localparam int CTRL_IRQ_EN  = 0;
   localparam int CTRL_CLR_ALL = 15;

   localparam logic [15:0] RSVD_RD_VAL = 16'hFFFF;

   localparam int BTN_BIG        = 0;
   localparam int BTN_MORSE_L    = 1;
   localparam int BTN_MORSE_R    = 2;
   localparam int BTN_MORSE_TX   = 3;
   localparam int BTN_KEY_TL     = 4;
   localparam int BTN_KEY_TR     = 5;
   localparam int BTN_KEY_LL     = 6;
   localparam int BTN_KEY_LR     = 7;

endpackage

// File: rtl/btn_debounce.sv
// One raw pin: 2-flop synchroniser, then a new level is accepted only after
// DEBOUNCE_CYCLES consecutive mismatching samples; edge pulses fire on the accept cycle.
module btn_debounce
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic rise_pulse_o,
   output logic fall_pulse_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mismatch;
   logic             accept;

   assign mismatch = sync_q[1] != stable_q;
   assign accept   = mismatch && (cnt_q == CNT_LAST);

   // Any cycle where the sample agrees with the held level restarts the count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (accept) begin
         stable_d = sync_q[1];
      end else if (mismatch) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[0], raw_i};
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level_o      = stable_q;
   assign rise_pulse_o = accept &&  sync_q[1];
   assign fall_pulse_o = accept && !sync_q[1];

endmodule

// File: rtl/button_event_ctrl.sv
// Debounced button levels, W1C press/release latches, CPU register window and masked irq.
// `define BUTTON_RELEASE_EVT_EN to implement release latching and let releases raise irq.
module button_event_ctrl
   import button_pkg::*;
#(
   parameter int DATA_WIDTH      = 16,
   parameter int ADDR_WIDTH      = 16,
   parameter int NUM_BTN         = 8,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_BTN-1:0]    btn_raw,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  irq
);

   logic [NUM_BTN-1:0] level, rise, fall;
   logic [NUM_BTN-1:0] press_q, press_d;
   logic [NUM_BTN-1:0] mask_q, mask_d;
   logic               irq_en_q, irq_en_d;
   logic               irq_q, irq_d;
   logic [2:0]         sel;
   logic               wr, clr_all;
   logic [NUM_BTN-1:0] w1c_press;
   logic               unused_bits;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk          (clk),
         .rst_n        (rst_n),
         .raw_i        (btn_raw[i]),
         .level_o      (level[i]),
         .rise_pulse_o (rise[i]),
         .fall_pulse_o (fall[i])
      );
   end

   assign sel       = addr[10:8];
   assign wr        = en && we;
   assign clr_all   = wr && (sel == REG_CTRL) && data[CTRL_CLR_ALL];
   assign w1c_press = (wr && sel == REG_PRESS) ? data[NUM_BTN-1:0] : '0;

   // New events are ORed in after the clears so a same-cycle set always survives.
   assign press_d  = (clr_all ? '0 : (press_q & ~w1c_press)) | rise;
   assign mask_d   = (wr && sel == REG_MASK) ? data[NUM_BTN-1:0] : mask_q;
   assign irq_en_d = (wr && sel == REG_CTRL) ? data[CTRL_IRQ_EN] : irq_en_q;

`ifdef BUTTON_RELEASE_EVT_EN
   logic [NUM_BTN-1:0] release_q, release_d;
   logic [NUM_BTN-1:0] w1c_release;

   assign w1c_release = (wr && sel == REG_RELEASE) ? data[NUM_BTN-1:0] : '0;
   assign release_d   = (clr_all ? '0 : (release_q & ~w1c_release)) | fall;
   assign irq_d       = irq_en_q && (|(press_q & mask_q) || |(release_q & mask_q));
   assign unused_bits = ^{addr, data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) release_q <= '0;
      else        release_q <= release_d;
   end
`else
   assign irq_d       = irq_en_q && |(press_q & mask_q);
   assign unused_bits = ^{addr, data, fall};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         press_q  <= '0;
         mask_q   <= '0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         press_q  <= press_d;
         mask_q   <= mask_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   always_comb begin
      q = '0;
      if (en) begin
         case (sel)
            REG_LEVEL: q = DATA_WIDTH'(level);
            REG_PRESS: q = DATA_WIDTH'(press_q);
`ifdef BUTTON_RELEASE_EVT_EN
            REG_RELEASE: q = DATA_WIDTH'(release_q);
`else
            REG_RELEASE: q = '0;
`endif
            REG_MASK: q = DATA_WIDTH'(mask_q);
            REG_CTRL: q = DATA_WIDTH'(irq_en_q);
            default:  q = DATA_WIDTH'(RSVD_RD_VAL);
         endcase
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with DEBOUNCE_CYCLES = 4 (accept 6 cycles after a raw edge).
module tb_button_event_ctrl;
   import button_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  btn_raw;
   logic        en, we;
   logic [15:0] addr, data;
   logic [15:0] q;
   logic        irq;
   logic [15:0] v;
   int          n_chk = 0;
   int          n_err = 0;

   button_event_ctrl #(
      .DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_BTN(8), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .en(en), .we(we),
      .addr(addr), .data(data), .q(q), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [2:0] sel, output logic [15:0] val);
      en   = 1'b1;
      we   = 1'b0;
      addr = {5'b0, sel, 8'h00};
      #1;
      val  = q;
      en   = 1'b0;
   endtask

   task automatic wr(input logic [2:0] sel, input logic [15:0] val);
      en   = 1'b1;
      we   = 1'b1;
      addr = {5'b0, sel, 8'h00};
      data = val;
      tick(1);
      en   = 1'b0;
      we   = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] sel, input logic [15:0] exp);
      logic [15:0] r;
      rd(sel, r);
      chk(tag, r, exp);
   endtask

   initial begin
      rst_n = 1'b0; btn_raw = 8'hFF; en = 1'b0; we = 1'b0; addr = '0; data = '0;

      // Reset state with all pins high
      tick(3);
      chk_reg("rst_level", REG_LEVEL, 16'h0000);
      chk_reg("rst_press", REG_PRESS, 16'h0000);
      chk_reg("rst_mask",  REG_MASK,  16'h0000);
      chk_reg("rst_ctrl",  REG_CTRL,  16'h0000);
      chk("rst_irq", {15'b0, irq}, 16'h0000);
      rst_n = 1'b1;
      tick(5);
      chk_reg("rst_level_c5", REG_LEVEL, 16'h0000);
      tick(1);
      chk_reg("rst_level_c6", REG_LEVEL, 16'h00FF);
      chk_reg("rst_press_c6", REG_PRESS, 16'h00FF);

      // Drop all pins, then clear-all wipes both pending registers
      btn_raw = 8'h00;
      tick(6);
      chk_reg("rel_level", REG_LEVEL, 16'h0000);
`ifdef BUTTON_RELEASE_EVT_EN
      chk_reg("rel_all", REG_RELEASE, 16'h00FF);
`else
      chk_reg("rel_all", REG_RELEASE, 16'h0000);
`endif
      wr(REG_CTRL, 16'h8000);
      chk_reg("clrall_press", REG_PRESS, 16'h0000);
      chk_reg("clrall_rel",   REG_RELEASE, 16'h0000);
      chk_reg("clrall_ctrl",  REG_CTRL, 16'h0000);

      // Bounce on bit 3: 2-cycle toggles never reach the terminal count
      for (int i = 0; i < 10; i++) begin
         btn_raw[BTN_MORSE_TX] = (i % 2 == 0);
         tick(2);
         chk_reg("bounce_level", REG_LEVEL, 16'h0000);
      end
      chk_reg("bounce_press", REG_PRESS, 16'h0000);
      btn_raw[BTN_MORSE_TX] = 1'b1;
      tick(5);
      chk_reg("bounce_press_c5", REG_PRESS, 16'h0000);
      tick(1);
      chk_reg("bounce_press_c6", REG_PRESS, 16'h0008);
      chk_reg("bounce_level_c6", REG_LEVEL, 16'h0008);
      wr(REG_PRESS, 16'h0008);
      chk_reg("w1c_bit3", REG_PRESS, 16'h0000);

      // IRQ path
      wr(REG_MASK, 16'h0001);
      wr(REG_CTRL, 16'h8001);
      chk_reg("ctrl_rb", REG_CTRL, 16'h0001);
      chk_reg("mask_rb", REG_MASK, 16'h0001);
      btn_raw[BTN_BIG] = 1'b1;
      tick(6);
      chk_reg("irq_press0", REG_PRESS, 16'h0001);
      chk("irq_same_cyc", {15'b0, irq}, 16'h0000);
      tick(1);
      chk("irq_set", {15'b0, irq}, 16'h0001);
      wr(REG_PRESS, 16'h0001);
      chk_reg("irq_w1c_press", REG_PRESS, 16'h0000);
      chk("irq_hold_one", {15'b0, irq}, 16'h0001);
      tick(1);
      chk("irq_clear", {15'b0, irq}, 16'h0000);
      btn_raw[BTN_MORSE_L] = 1'b1;
      tick(7);
      chk_reg("unmasked_press", REG_PRESS, 16'h0002);
      chk("irq_masked", {15'b0, irq}, 16'h0000);

      // W1C on bit 5 lands on the same edge its press is accepted
      btn_raw[BTN_KEY_TR] = 1'b1;
      tick(5);
      wr(REG_PRESS, 16'h0020);
      chk_reg("collision", REG_PRESS, 16'h0022);

      // Press then release bit 7
      btn_raw[BTN_KEY_LR] = 1'b1;
      tick(6);
      btn_raw[BTN_KEY_LR] = 1'b0;
      tick(6);
      chk_reg("press7", REG_PRESS, 16'h00A2);
`ifdef BUTTON_RELEASE_EVT_EN
      chk_reg("release7", REG_RELEASE, 16'h0080);
`else
      chk_reg("release7", REG_RELEASE, 16'h0000);
`endif
      chk_reg("rsvd5", 3'd5, 16'hFFFF);
      chk_reg("rsvd6", 3'd6, 16'hFFFF);
      chk_reg("rsvd7", 3'd7, 16'hFFFF);
      wr(3'd6, 16'h0000);
      chk_reg("rsvd_wr_level", REG_LEVEL, 16'h002B);
      en = 1'b0; addr = {5'b0, REG_LEVEL, 8'h00};
      #1;
      chk("en_low", q, 16'h0000);

      // Reset pulse while bit 2 is two counts into its debounce
      btn_raw[BTN_MORSE_R] = 1'b1;
      tick(4);
      rst_n = 1'b0;
      #1;
      chk_reg("midrst_level", REG_LEVEL, 16'h0000);
      chk_reg("midrst_press", REG_PRESS, 16'h0000);
      tick(1);
      rst_n = 1'b1;
      tick(5);
      chk_reg("midrst_c5", REG_LEVEL, 16'h0000);
      tick(1);
      chk_reg("midrst_c6", REG_LEVEL, 16'h002F);
      chk_reg("midrst_press_c6", REG_PRESS, 16'h002F);
      chk("midrst_irq", {15'b0, irq}, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Input controller for the bomb-module push buttons (big button, morse left/right/tx, four keypad keys). Synchronises and debounces each raw pin, holds stable levels, and latches press/release events until software clears them. Gives the CPU a memory-mapped read/write window and a maskable interrupt line. Sits between the board pins and the CPU data bus, alongside the OLED/LED write decode in the IO space.

## Interface
- DATA_WIDTH, 16, bus data width
- ADDR_WIDTH, 16, bus address width; only addr[10:8] decoded
- NUM_BTN, 8, number of button inputs (≤ DATA_WIDTH)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new level (≥ 2)

- clk  in  1  system clock, sole clock domain
- rst_n  in  1  asynchronous, active-low reset
- btn_raw  in  NUM_BTN  asynchronous raw pins; bit 0 big button, 1 morse_left, 2 morse_right, 3 morse_tx, 4 keypad_TL, 5 keypad_TR, 6 keypad_LL, 7 keypad_LR; active-high
- en  in  1  bus select for this block
- we  in  1  write strobe, qualified by en
- addr  in  ADDR_WIDTH  bus address
- data  in  DATA_WIDTH  write data
- q  out  DATA_WIDTH  read data (combinational)
- irq  out  1  registered interrupt, level

## Operation
- Per button: 2-flop synchroniser → debounce counter → stable register.
- Debounce: sync == stable → count = 0. sync != stable → count increments. When count == DEBOUNCE_CYCLES-1 and still mismatched: stable <= sync, count <= 0. A mismatch that reverts before terminal count discards the partial count.
- Stable 0→1 sets press_pend[i]. Stable 1→0 sets release_pend[i].
- Register map by addr[10:8]:
  - 000 LEVEL (RO): stable levels, zero-extended.
  - 001 PRESS (R/W1C): press_pend.
  - 010 RELEASE (R/W1C): release_pend.
  - 011 MASK (RW): irq_mask[NUM_BTN-1:0].
  - 100 CTRL (RW): bit0 irq_en. Bit 15 (W only, reads 0) is a clear-all pulse that zeroes both pending registers.
  - 101–111: read 16'hFFFF; writes ignored.
- Write takes effect on the clk edge where en && we.
- W1C and a new event on the same bit in the same cycle: the set wins, and the bit stays 1.
- Reads have no side effects.
- q = 0 when en = 0.
- Unused upper bits read 0.
- irq next = irq_en && |(press_pend & irq_mask). With RELEASE_EVT_EN it also ORs in |(release_pend & irq_mask).

## Timing
- Reset values: q combinational (0 while en = 0); irq = 0; stable = 0; counters = 0; synchronisers = 0; press_pend = release_pend = 0; irq_mask = 0; irq_en = 0.
- Raw edge to stable update: 2 + DEBOUNCE_CYCLES cycles, assuming the raw level is held. Pending bit updates on that same edge.
- Pending bit to irq: 1 cycle.
- W1C to pending 0 and irq deassert: pending clears on the write edge; irq drops 1 cycle later.
- Reset asserted mid-debounce: all state clears immediately. After release, a held-high pin is re-accepted after 2 + DEBOUNCE_CYCLES cycles and produces a press event.

## Configuration
- Macro: BUTTON_RELEASE_EVT_EN.
- Defined: release_pend is implemented, register 010 is live, and release events feed irq.
- Undefined: no release_pend flops; 010 reads 0 and writes are ignored; irq uses press events only.

## Structure
- Shared package `button_pkg`:
  - register offsets for addr[10:8] (REG_LEVEL, REG_PRESS, REG_RELEASE, REG_MASK, REG_CTRL)
  - CTRL bit positions
  - reserved read value 16'hFFFF
  - button index constants (BTN_BIG … BTN_KEY_LR)
- Sub-module `btn_debounce`: one per button, generate loop. Contains synchroniser, counter and stable register; outputs level, rise_pulse and fall_pulse. Event latching, register file and irq stay in the top.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: hold rst_n = 0 with btn_raw = 8'hFF → q(en=1, LEVEL) = 0, irq = 0. Release reset → LEVEL = 16'h00FF exactly 6 cycles later; PRESS = 16'h00FF.
- Bounce: btn_raw[3] toggles every 2 cycles for 20 cycles, then holds 1 → no LEVEL change during toggling; exactly one PRESS bit 3 event, 6 cycles after the final edge.
- IRQ: MASK = 16'h0001, CTRL = 1, press bit 0 → irq = 1 one cycle after PRESS[0] sets. Write PRESS = 16'h0001 → PRESS = 0, irq = 0 one cycle later. Bit 1 press with mask bit 1 clear → irq stays 0.
- Collision: W1C PRESS bit 5 on the same edge bit 5's stable goes 0→1 → PRESS[5] reads 1 afterwards.
- Release and reserved addresses: press then release bit 7 → RELEASE = 16'h0080 with BUTTON_RELEASE_EVT_EN, 0 without. Read addr[10:8] = 110 → 16'hFFFF. en = 0 → q = 0.
- Reset mid-debounce: pulse rst_n low at count 2 on bit 2 → no event. LEVEL[2] = 1 six cycles after rst_n rises, with raw held high.
